// File: rtl/noc_ref_pkg.sv
// Shared definitions for the 2D NoC reference traffic generator/checker.
//   LFSR_TAPS  : Galois taps of the 32-bit stream LFSR
//   lfsr_next  : one LFSR step (shift right, XOR taps when bit0 was set)
//   LED_*      : bit positions inside led_l
//   lane_t     : valid + LFSR data of one stream sender
package noc_ref_pkg;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  localparam int LED_PLL_LOCK  = 0;
  localparam int LED_AXI_FAIL  = 1;
  localparam int LED_H_SEEN    = 2;
  localparam int LED_V_SEEN    = 3;
  localparam int LED_AXI_DONE  = 4;
  localparam int LED_V_FAIL    = 5;
  localparam int LED_H_FAIL    = 6;
  localparam int LED_HEARTBEAT = 7;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } lane_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
    lfsr_next = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
  endfunction

endpackage

// File: rtl/lfsr_lane_checker.sv
// Receive-side checker for one LFSR stream lane (chk_clk domain).
//   clk, rst          : checker clock, active-high async reset (already synchronised)
//   start             : enable; rx_ready rises the cycle after it is sampled high
//   rx_valid/rx_ready/rx_data : incoming stream
//   fail              : sticky, set one cycle after a beat that differs from the model
//   seen              : sticky, at least one beat has been checked
//   beat_cnt          : checked-beat counter, present only with NOC_REF_BEAT_COUNT_EN
module lfsr_lane_checker
  import noc_ref_pkg::*;
#(
  parameter int          DATA_W = 32,
  parameter logic [31:0] SEED   = 32'h0000_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data,
  output logic              fail,
  output logic              seen
`ifdef NOC_REF_BEAT_COUNT_EN
  ,
  output logic [31:0]       beat_cnt
`endif
);

  logic [31:0] expect_q;
  logic        accept;

  assign accept = rx_valid & rx_ready;

  // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready <= 1'b0;
      expect_q <= SEED;
      fail     <= 1'b0;
      seen     <= 1'b0;
    end else begin
      if (start) rx_ready <= 1'b1;
      if (accept) begin
        expect_q <= lfsr_next(expect_q);
        seen     <= 1'b1;
        if (rx_data != DATA_W'(expect_q)) fail <= 1'b1;
      end
    end
  end

`ifdef NOC_REF_BEAT_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         beat_cnt <= '0;
    else if (accept) beat_cnt <= beat_cnt + 32'd1;
  end
`endif

endmodule

// File: rtl/noc_2d_ref_design.sv
// Traffic generator / self-checker top of the 2D NoC reference design.
//   send_clk, reset_n (async, ACTIVE-HIGH), chk_clk, reg_clk (heartbeat only)
//   pll_*_lock        : PLL lock inputs, ANDed onto led_l[0]
//   test_start_*      : lane enables (send_* / axi in send_clk, *_chk in chk_clk)
//   h_tx_*, v_tx_*    : LFSR stream senders (send_clk)
//   h_rx_*, v_rx_*    : LFSR stream checkers (chk_clk)
//   axi_req_*/axi_rsp_* : in-order memory read test (send_clk)
//   led_l, led_l_oe   : status LEDs (map in noc_ref_pkg), enables always on
// Optional build macro NOC_REF_BEAT_COUNT_EN adds h_beat_cnt / v_beat_cnt.
module noc_2d_ref_design
  import noc_ref_pkg::*;
#(
  parameter int          DATA_W          = 32,
  parameter logic [31:0] SEED_H          = 32'h0000_0001,
  parameter logic [31:0] SEED_V          = 32'h0000_0002,
  parameter int          NUM_AXI_XACT    = 64,
  parameter int          MAX_OUTSTANDING = 8
) (
  input  logic              send_clk,
  input  logic              reset_n,
  input  logic              chk_clk,
  input  logic              reg_clk,
  input  logic              pll_send_clk_lock,
  input  logic              pll_chk_clk_lock,
  input  logic              test_start_h_send,
  input  logic              test_start_v_send,
  input  logic              test_start_axi,
  input  logic              test_start_h_chk,
  input  logic              test_start_v_chk,
  output logic              h_tx_valid,
  input  logic              h_tx_ready,
  output logic [DATA_W-1:0] h_tx_data,
  output logic              v_tx_valid,
  input  logic              v_tx_ready,
  output logic [DATA_W-1:0] v_tx_data,
  input  logic              h_rx_valid,
  output logic              h_rx_ready,
  input  logic [DATA_W-1:0] h_rx_data,
  input  logic              v_rx_valid,
  output logic              v_rx_ready,
  input  logic [DATA_W-1:0] v_rx_data,
  output logic              axi_req_valid,
  input  logic              axi_req_ready,
  output logic [31:0]       axi_req_addr,
  input  logic              axi_rsp_valid,
  input  logic [DATA_W-1:0] axi_rsp_data,
`ifdef NOC_REF_BEAT_COUNT_EN
  output logic [31:0]       h_beat_cnt,
  output logic [31:0]       v_beat_cnt,
`endif
  output logic [7:0]        led_l,
  output logic [7:0]        led_l_oe
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  // ---------------- stream senders ----------------
  lane_t h_q, v_q;

  always_ff @(posedge send_clk or posedge reset_n) begin
    if (reset_n) begin
      h_q <= '{valid: 1'b0, data: SEED_H};
    end else begin
      if (test_start_h_send) h_q.valid <= 1'b1;
      // Advancing only on handshake keeps data held through any stall.
      if (h_q.valid && h_tx_ready) h_q.data <= lfsr_next(h_q.data);
    end
  end

  always_ff @(posedge send_clk or posedge reset_n) begin
    if (reset_n) begin
      v_q <= '{valid: 1'b0, data: SEED_V};
    end else begin
      if (test_start_v_send) v_q.valid <= 1'b1;
      if (v_q.valid && v_tx_ready) v_q.data <= lfsr_next(v_q.data);
    end
  end

  assign h_tx_valid = h_q.valid;
  assign h_tx_data  = DATA_W'(h_q.data);
  assign v_tx_valid = v_q.valid;
  assign v_tx_data  = DATA_W'(v_q.data);

  // ---------------- checker-domain reset ----------------
  // NOTE: reset enters chk_clk asynchronously but leaves through two flops,
  // so release never lands inside a chk_clk setup window.
  logic [1:0] chk_rst_sync;
  logic       chk_rst;

  always_ff @(posedge chk_clk or posedge reset_n) begin
    if (reset_n) chk_rst_sync <= 2'b11;
    else         chk_rst_sync <= {chk_rst_sync[0], 1'b0};
  end

  assign chk_rst = chk_rst_sync[1];

  // ---------------- stream checkers ----------------
  logic h_fail, h_seen, v_fail, v_seen;

  lfsr_lane_checker #(.DATA_W(DATA_W), .SEED(SEED_H)) u_h_chk (
    .clk      (chk_clk),
    .rst      (chk_rst),
    .start    (test_start_h_chk),
    .rx_valid (h_rx_valid),
    .rx_ready (h_rx_ready),
    .rx_data  (h_rx_data),
    .fail     (h_fail),
    .seen     (h_seen)
`ifdef NOC_REF_BEAT_COUNT_EN
    ,
    .beat_cnt (h_beat_cnt)
`endif
  );

  lfsr_lane_checker #(.DATA_W(DATA_W), .SEED(SEED_V)) u_v_chk (
    .clk      (chk_clk),
    .rst      (chk_rst),
    .start    (test_start_v_chk),
    .rx_valid (v_rx_valid),
    .rx_ready (v_rx_ready),
    .rx_data  (v_rx_data),
    .fail     (v_fail),
    .seen     (v_seen)
`ifdef NOC_REF_BEAT_COUNT_EN
    ,
    .beat_cnt (v_beat_cnt)
`endif
  );

  // ---------------- memory lane ----------------
  logic              axi_run;
  logic [31:0]       issued_q;
  logic [31:0]       rsp_cnt_q;
  logic [OUT_W-1:0]  outstanding_q;
  logic              axi_fail_q;
  logic              req_fire;
  logic              rsp_ok;
  logic [15:0]       rsp_addr;
  logic [DATA_W-1:0] rsp_expect;

  // Once raised, valid can only be dropped by an issue: responses only lower
  // the outstanding count, so request hold until ready is implicit.
  assign axi_req_valid = axi_run
                      && (issued_q < 32'(NUM_AXI_XACT))
                      && (outstanding_q < OUT_W'(MAX_OUTSTANDING));
  assign axi_req_addr  = issued_q << 2;
  assign req_fire      = axi_req_valid & axi_req_ready;
  assign rsp_ok        = axi_rsp_valid && (outstanding_q != '0);
  assign rsp_addr      = 16'(rsp_cnt_q << 2);
  assign rsp_expect    = DATA_W'({rsp_addr, ~rsp_addr});

  always_ff @(posedge send_clk or posedge reset_n) begin
    if (reset_n) begin
      axi_run       <= 1'b0;
      issued_q      <= '0;
      rsp_cnt_q     <= '0;
      outstanding_q <= '0;
      axi_fail_q    <= 1'b0;
    end else begin
      if (test_start_axi) axi_run <= 1'b1;
      if (req_fire)       issued_q  <= issued_q + 32'd1;
      if (rsp_ok)         rsp_cnt_q <= rsp_cnt_q + 32'd1;
      case ({req_fire, rsp_ok})
        2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - OUT_W'(1);
        default: outstanding_q <= outstanding_q;
      endcase
      // A response with nothing in flight is a protocol error; data is not compared then.
      if (axi_rsp_valid && (!rsp_ok || axi_rsp_data != rsp_expect)) axi_fail_q <= 1'b1;
    end
  end

  // ---------------- heartbeat ----------------
  logic [26:0] hb_q;

  always_ff @(posedge reg_clk or posedge reset_n) begin
    if (reset_n) hb_q <= '0;
    else         hb_q <= hb_q + 27'd1;
  end

  // ---------------- LEDs ----------------
  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    led_l                = '0;
    led_l[LED_PLL_LOCK]  = pll_send_clk_lock & pll_chk_clk_lock;
    led_l[LED_AXI_FAIL]  = axi_fail_q;
    led_l[LED_H_SEEN]    = h_seen;
    led_l[LED_V_SEEN]    = v_seen;
    led_l[LED_AXI_DONE]  = (rsp_cnt_q == 32'(NUM_AXI_XACT));
    led_l[LED_V_FAIL]    = v_fail;
    led_l[LED_H_FAIL]    = h_fail;
    led_l[LED_HEARTBEAT] = hb_q[26];
  end

  assign led_l_oe = 8'hFF;

endmodule

// File: tb/tb_noc_2d_ref_design.sv
// Directed self-checking bench for noc_2d_ref_design: reset state, H/V
// loopback, corrupted beat, memory responder, outstanding limit and spurious
// response, random stalls with a mid-run reset.
module tb_noc_2d_ref_design;

  logic        send_clk = 1'b0;
  logic        chk_clk  = 1'b0;
  logic        reg_clk  = 1'b0;
  logic        reset_n;
  logic        pll_send_clk_lock, pll_chk_clk_lock;
  logic        test_start_h_send, test_start_v_send, test_start_axi;
  logic        test_start_h_chk, test_start_v_chk;
  logic        h_tx_valid, h_tx_ready, v_tx_valid, v_tx_ready;
  logic [31:0] h_tx_data, v_tx_data;
  logic        h_rx_valid, h_rx_ready, v_rx_valid, v_rx_ready;
  logic [31:0] h_rx_data, v_rx_data;
  logic        axi_req_valid, axi_req_ready;
  logic [31:0] axi_req_addr;
  logic        axi_rsp_valid;
  logic [31:0] axi_rsp_data;
  logic [7:0]  led_l, led_l_oe;
`ifdef NOC_REF_BEAT_COUNT_EN
  logic [31:0] h_beat_cnt, v_beat_cnt;
`endif

  // loopback control
  logic h_stall = 1'b0, v_stall = 1'b0, h_flip = 1'b0;

  assign h_rx_valid = h_tx_valid & ~h_stall;
  assign h_tx_ready = h_rx_ready & ~h_stall;
  assign h_rx_data  = h_tx_data ^ {31'b0, h_flip};
  assign v_rx_valid = v_tx_valid & ~v_stall;
  assign v_tx_ready = v_rx_ready & ~v_stall;
  assign v_rx_data  = v_tx_data;

  always #5 send_clk = ~send_clk;
  always #5 chk_clk  = ~chk_clk;
  always #7 reg_clk  = ~reg_clk;

  noc_2d_ref_design dut (
    .send_clk          (send_clk),
    .reset_n           (reset_n),
    .chk_clk           (chk_clk),
    .reg_clk           (reg_clk),
    .pll_send_clk_lock (pll_send_clk_lock),
    .pll_chk_clk_lock  (pll_chk_clk_lock),
    .test_start_h_send (test_start_h_send),
    .test_start_v_send (test_start_v_send),
    .test_start_axi    (test_start_axi),
    .test_start_h_chk  (test_start_h_chk),
    .test_start_v_chk  (test_start_v_chk),
    .h_tx_valid        (h_tx_valid),
    .h_tx_ready        (h_tx_ready),
    .h_tx_data         (h_tx_data),
    .v_tx_valid        (v_tx_valid),
    .v_tx_ready        (v_tx_ready),
    .v_tx_data         (v_tx_data),
    .h_rx_valid        (h_rx_valid),
    .h_rx_ready        (h_rx_ready),
    .h_rx_data         (h_rx_data),
    .v_rx_valid        (v_rx_valid),
    .v_rx_ready        (v_rx_ready),
    .v_rx_data         (v_rx_data),
    .axi_req_valid     (axi_req_valid),
    .axi_req_ready     (axi_req_ready),
    .axi_req_addr      (axi_req_addr),
    .axi_rsp_valid     (axi_rsp_valid),
    .axi_rsp_data      (axi_rsp_data),
`ifdef NOC_REF_BEAT_COUNT_EN
    .h_beat_cnt        (h_beat_cnt),
    .v_beat_cnt        (v_beat_cnt),
`endif
    .led_l             (led_l),
    .led_l_oe          (led_l_oe)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Independent reference: right shift, XOR 0x80200003 when the old bit0 was 1.
  function automatic logic [31:0] lfsr_model(input logic [31:0] cur);
    logic [31:0] nxt;
    nxt = {1'b0, cur[31:1]};
    if (cur[0]) nxt = nxt ^ 32'h8020_0003;
    return nxt;
  endfunction

  logic [31:0] h_beats[$];
  logic [31:0] v_beats[$];
  logic        h_fail_before, v_fail_before, h_fail_after;
  logic [1:0]  seen_before;

  // Starts at a negedge; every iteration ends on the following negedge.
  task automatic lane_cycles(input int ncyc, input bit stall_en, input bit flip_en);
    for (int c = 0; c < ncyc; c++) begin
      h_stall = stall_en && ($urandom_range(0, 3) == 0);
      v_stall = stall_en && ($urandom_range(0, 3) == 0);
      #1;
      if (h_tx_valid && h_tx_ready) begin
        h_beats.push_back(h_tx_data);
        if (flip_en && h_beats.size() == 10) begin
          h_flip        = 1'b1;
          h_fail_before = led_l[6];
          v_fail_before = led_l[5];
          seen_before   = led_l[3:2];
        end
      end
      if (v_tx_valid && v_tx_ready) v_beats.push_back(v_tx_data);
      @(negedge send_clk);
      if (h_flip) begin
        h_fail_after = led_l[6];
        h_flip       = 1'b0;
      end
    end
  endtask

  task automatic check_stream(input string tag, input logic [31:0] seed, input bit is_h);
    logic [31:0] exp;
    int          n;
    exp = seed;
    n   = is_h ? h_beats.size() : v_beats.size();
    for (int i = 0; i < n; i++) begin
      check(tag, is_h ? h_beats[i] : v_beats[i], exp);
      exp = lfsr_model(exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge send_clk);
    reset_n = 1'b1;
    repeat (2) @(negedge send_clk);
    reset_n = 1'b0;
  endtask

  // memory responder state
  int          rsp_due[$];
  logic [31:0] rsp_addr_q[$];

  initial begin
    int          cyc, n_acc, hold_err, max_out, n_rsp;
    logic        pend_valid;
    logic [31:0] pend_addr, last_addr, a;

    reset_n           = 1'b1;
    pll_send_clk_lock = 1'b1;
    pll_chk_clk_lock  = 1'b1;
    test_start_h_send = 1'b0;
    test_start_v_send = 1'b0;
    test_start_axi    = 1'b0;
    test_start_h_chk  = 1'b0;
    test_start_v_chk  = 1'b0;
    axi_req_ready     = 1'b0;
    axi_rsp_valid     = 1'b0;
    axi_rsp_data      = '0;

    // ---- reset state ----
    repeat (3) @(negedge send_clk);
    check("rst_tx_valid", {h_tx_valid, v_tx_valid}, 2'b00);
    check("rst_rx_ready", {h_rx_ready, v_rx_ready}, 2'b00);
    check("rst_req_valid", axi_req_valid, 1'b0);
    check("rst_req_addr", axi_req_addr, 32'h0);
    check("rst_led", led_l, 8'h01);
    check("rst_led_oe", led_l_oe, 8'hFF);
    pll_chk_clk_lock = 1'b0;
    #1;
    check("led_lock_low", led_l, 8'h00);
    pll_chk_clk_lock = 1'b1;

    // ---- release, idle without start ----
    @(negedge send_clk);
    reset_n = 1'b0;
    repeat (4) @(negedge send_clk);
    check("idle_tx_valid", {h_tx_valid, v_tx_valid}, 2'b00);

    // ---- loopback with corrupted 10th H beat ----
    test_start_h_send = 1'b1;
    test_start_v_send = 1'b1;
    test_start_h_chk  = 1'b1;
    test_start_v_chk  = 1'b1;
    @(negedge send_clk);
    check("tx_valid_rise", {h_tx_valid, v_tx_valid}, 2'b11);
    lane_cycles(20, 1'b0, 1'b1);
    check("h_first_beat", h_beats[0], 32'h0000_0001);
    check("v_first_beat", v_beats[0], 32'h0000_0002);
    check_stream("h_beat", 32'h0000_0001, 1'b1);
    check_stream("v_beat", 32'h0000_0002, 1'b0);
    check("h_fail_before_bad", h_fail_before, 1'b0);
    check("v_fail_before_bad", v_fail_before, 1'b0);
    check("seen_leds", seen_before, 2'b11);
    check("h_fail_one_later", h_fail_after, 1'b1);
    check("h_fail_sticky", led_l[6], 1'b1);
    check("v_fail_clean", led_l[5], 1'b0);
`ifdef NOC_REF_BEAT_COUNT_EN
    check("h_beat_cnt", h_beat_cnt, 32'(h_beats.size()));
    check("v_beat_cnt", v_beat_cnt, 32'(v_beats.size()));
`endif

    // ---- stalls, then mid-run reset ----
    lane_cycles(5, 1'b1, 1'b0);
    reset_n = 1'b1;
    #1;
    check("midrst_tx_valid", {h_tx_valid, v_tx_valid}, 2'b00);
    check("midrst_rx_ready", {h_rx_ready, v_rx_ready}, 2'b00);
    check("midrst_led", led_l[6:1], 6'h00);
    h_beats.delete();
    v_beats.delete();
    @(negedge send_clk);
    reset_n = 1'b0;
    lane_cycles(200, 1'b1, 1'b0);
    check("post_rst_first_beat", h_beats[0], 32'h0000_0001);
    check_stream("stall_h_beat", 32'h0000_0001, 1'b1);
    check_stream("stall_v_beat", 32'h0000_0002, 1'b0);
    check("stall_traffic_seen", h_beats.size() > 50, 1'b1);
    check("stall_fail_leds", led_l[6:5], 2'b00);

    // ---- memory responder, 3-cycle latency, periodic ready gaps ----
    pulse_reset();
    test_start_axi = 1'b1;
    cyc = 0; n_acc = 0; hold_err = 0; max_out = 0; n_rsp = 0;
    pend_valid = 1'b0; pend_addr = '0; last_addr = '0;
    check("axi_done_low", led_l[4], 1'b0);
    while (!led_l[4] && cyc < 1000) begin
      @(negedge send_clk);
      cyc++;
      if (pend_valid && (!axi_req_valid || axi_req_addr != pend_addr)) hold_err++;
      axi_req_ready = (cyc % 5) != 0;
      pend_valid    = axi_req_valid && !axi_req_ready;
      pend_addr     = axi_req_addr;
      if (n_acc - n_rsp > max_out) max_out = n_acc - n_rsp;
      if (axi_req_valid && axi_req_ready) begin
        rsp_due.push_back(cyc + 3);
        rsp_addr_q.push_back(axi_req_addr);
        last_addr = axi_req_addr;
        n_acc++;
      end
      axi_rsp_valid = 1'b0;
      if (rsp_due.size() > 0 && rsp_due[0] <= cyc) begin
        void'(rsp_due.pop_front());
        a             = rsp_addr_q.pop_front();
        axi_rsp_valid = 1'b1;
        axi_rsp_data  = {a[15:0], ~a[15:0]};
        n_rsp++;
      end
    end
    check("axi_accepts", n_acc, 64);
    check("axi_last_addr", last_addr, 32'h0000_00FC);
    check("axi_done", led_l[4], 1'b1);
    check("axi_no_fail", led_l[1], 1'b0);
    check("axi_req_hold", hold_err, 0);
    check("axi_out_bound", max_out <= 8, 1'b1);
    check("axi_valid_after_done", axi_req_valid, 1'b0);

    // ---- outstanding limit, then spurious response ----
    axi_rsp_valid = 1'b0;
    axi_req_ready = 1'b1;
    pulse_reset();
    n_acc = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge send_clk);
      if (axi_req_valid && axi_req_ready) n_acc++;
    end
    check("outstanding_cap", n_acc, 8);
    check("req_valid_at_cap", axi_req_valid, 1'b0);
    axi_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a             = 32'(i * 4);
      axi_rsp_valid = 1'b1;
      axi_rsp_data  = {a[15:0], ~a[15:0]};
      @(negedge send_clk);
    end
    axi_rsp_valid = 1'b0;
    @(negedge send_clk);
    check("drain_no_fail", led_l[1], 1'b0);
    check("drain_not_done", led_l[4], 1'b0);
    axi_rsp_valid = 1'b1;
    axi_rsp_data  = 32'h0020_FFDF;
    @(negedge send_clk);
    axi_rsp_valid = 1'b0;
    check("spurious_fail", led_l[1], 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
